// File: rtl/ex_stage.sv
// MIPS execute stage: combinational logic/shift/arith/move ALU plus a radix-2
// restoring divider that stalls the pipeline and owns the architectural HI/LO.
module ex_stage #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int REG_DATA_WIDTH = 32,
    parameter int ALUSEL_WIDTH   = 3,
    parameter int ALUOP_WIDTH    = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [REG_ADDR_WIDTH-1:0] reg_wr_addr_in,
    input  logic                      reg_wr_en_in,
    input  logic [REG_DATA_WIDTH-1:0] reg_rd_data1_in,
    input  logic [REG_DATA_WIDTH-1:0] reg_rd_data2_in,
    input  logic [ALUSEL_WIDTH-1:0]   alusel_in,
    input  logic [ALUOP_WIDTH-1:0]    aluop_in,
    input  logic                      flush_in,
    output logic [REG_ADDR_WIDTH-1:0] reg_wr_addr_out,
    output logic                      reg_wr_en_out,
    output logic [REG_DATA_WIDTH-1:0] reg_wr_data_out,
    output logic                      stall_req_out,
    output logic [REG_DATA_WIDTH-1:0] hi_out,
    output logic [REG_DATA_WIDTH-1:0] lo_out
);
    localparam int W  = REG_DATA_WIDTH;
    localparam int CW = $clog2(REG_DATA_WIDTH);

    localparam logic [ALUSEL_WIDTH-1:0] SEL_LOGIC = ALUSEL_WIDTH'(1);
    localparam logic [ALUSEL_WIDTH-1:0] SEL_SHIFT = ALUSEL_WIDTH'(2);
    localparam logic [ALUSEL_WIDTH-1:0] SEL_ARITH = ALUSEL_WIDTH'(3);
    localparam logic [ALUSEL_WIDTH-1:0] SEL_MOVE  = ALUSEL_WIDTH'(4);
    localparam logic [ALUSEL_WIDTH-1:0] SEL_DIV   = ALUSEL_WIDTH'(5);

    localparam logic [ALUOP_WIDTH-1:0] OP_AND  = ALUOP_WIDTH'(8'h24);
    localparam logic [ALUOP_WIDTH-1:0] OP_OR   = ALUOP_WIDTH'(8'h25);
    localparam logic [ALUOP_WIDTH-1:0] OP_XOR  = ALUOP_WIDTH'(8'h26);
    localparam logic [ALUOP_WIDTH-1:0] OP_NOR  = ALUOP_WIDTH'(8'h27);
    localparam logic [ALUOP_WIDTH-1:0] OP_SLL  = ALUOP_WIDTH'(8'h7C);
    localparam logic [ALUOP_WIDTH-1:0] OP_SRL  = ALUOP_WIDTH'(8'h02);
    localparam logic [ALUOP_WIDTH-1:0] OP_SRA  = ALUOP_WIDTH'(8'h03);
    localparam logic [ALUOP_WIDTH-1:0] OP_ADD  = ALUOP_WIDTH'(8'h20);
    localparam logic [ALUOP_WIDTH-1:0] OP_ADDU = ALUOP_WIDTH'(8'h21);
    localparam logic [ALUOP_WIDTH-1:0] OP_SUB  = ALUOP_WIDTH'(8'h22);
    localparam logic [ALUOP_WIDTH-1:0] OP_SUBU = ALUOP_WIDTH'(8'h23);
    localparam logic [ALUOP_WIDTH-1:0] OP_SLT  = ALUOP_WIDTH'(8'h2A);
    localparam logic [ALUOP_WIDTH-1:0] OP_SLTU = ALUOP_WIDTH'(8'h2B);
    localparam logic [ALUOP_WIDTH-1:0] OP_MFHI = ALUOP_WIDTH'(8'h10);
    localparam logic [ALUOP_WIDTH-1:0] OP_MFLO = ALUOP_WIDTH'(8'h12);
    localparam logic [ALUOP_WIDTH-1:0] OP_DIV  = ALUOP_WIDTH'(8'h1A);
    localparam logic [ALUOP_WIDTH-1:0] OP_DIVU = ALUOP_WIDTH'(8'h1B);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} div_state_t;

    div_state_t      state;
    logic [W-1:0]    quot_q, rem_q, dsr_q, hi_q, lo_q;
    logic [CW-1:0]   cnt_q;
    logic            neg_quot_q, neg_rem_q;

    logic [W-1:0]    op_a, op_b, sum, diff;
    logic            add_ovf, sub_ovf;
    logic [CW-1:0]   shamt;

    assign op_a  = reg_rd_data1_in;
    assign op_b  = reg_rd_data2_in;
    assign shamt = reg_rd_data2_in[CW-1:0];
    assign sum   = op_a + op_b;
    assign diff  = op_a - op_b;
    // Signed overflow: operands agree (add) or differ (sub) in sign, result sign flips.
    assign add_ovf = (op_a[W-1] == op_b[W-1]) && (sum[W-1]  != op_a[W-1]);
    assign sub_ovf = (op_a[W-1] != op_b[W-1]) && (diff[W-1] != op_a[W-1]);

    logic            div_op, div_signed, div_req, a_neg, b_neg;
    logic [W-1:0]    abs_a, abs_b;

    assign div_op     = (alusel_in == SEL_DIV) && ((aluop_in == OP_DIV) || (aluop_in == OP_DIVU));
    assign div_signed = (aluop_in == OP_DIV);
    assign div_req    = div_op && !flush_in;
    assign a_neg      = div_signed && op_a[W-1];
    assign b_neg      = div_signed && op_b[W-1];
    assign abs_a      = a_neg ? -op_a : op_a;
    assign abs_b      = b_neg ? -op_b : op_b;

    // One restoring step: shift the next dividend bit into the partial remainder and
    // keep the subtraction only if it did not borrow.
    logic [W:0]      rem_shift, trial;
    logic [W-1:0]    quot_fin, rem_fin;

    assign rem_shift = {rem_q, quot_q[W-1]};
    assign trial     = rem_shift - {1'b0, dsr_q};
    assign quot_fin  = neg_quot_q ? -quot_q : quot_q;
    assign rem_fin   = neg_rem_q  ? -rem_q  : rem_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            quot_q     <= '0;
            rem_q      <= '0;
            dsr_q      <= '0;
            cnt_q      <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else if (flush_in) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (div_req) begin
                        neg_rem_q <= a_neg;
                        dsr_q     <= abs_b;
                        cnt_q     <= '0;
                        if (op_b == '0) begin
                            // Divide by zero: LO all ones, HI = dividend (sign restored in DONE).
                            quot_q     <= '1;
                            rem_q      <= abs_a;
                            neg_quot_q <= 1'b0;
                            state      <= S_DONE;
                        end else begin
                            quot_q     <= abs_a;
                            rem_q      <= '0;
                            neg_quot_q <= a_neg ^ b_neg;
                            state      <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    if (!trial[W]) begin
                        rem_q  <= trial[W-1:0];
                        quot_q <= {quot_q[W-2:0], 1'b1};
                    end else begin
                        rem_q  <= rem_shift[W-1:0];
                        quot_q <= {quot_q[W-2:0], 1'b0};
                    end
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(W - 1)) state <= S_DONE;
                end
                S_DONE: begin
                    hi_q  <= rem_fin;
                    lo_q  <= quot_fin;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    logic [W-1:0] result;
    logic         wr_en;

    always_comb begin
        // NOTE: defaults before the case keep every path assigned, so no latch is inferred.
        result = '0;
        wr_en  = reg_wr_en_in;
        case (alusel_in)
            SEL_LOGIC: begin
                case (aluop_in)
                    OP_AND:  result = op_a & op_b;
                    OP_OR:   result = op_a | op_b;
                    OP_XOR:  result = op_a ^ op_b;
                    OP_NOR:  result = ~(op_a | op_b);
                    default: result = '0;
                endcase
            end
            SEL_SHIFT: begin
                case (aluop_in)
                    OP_SLL:  result = op_a << shamt;
                    OP_SRL:  result = op_a >> shamt;
                    OP_SRA:  result = W'($signed(op_a) >>> shamt);
                    default: result = '0;
                endcase
            end
            SEL_ARITH: begin
                case (aluop_in)
                    OP_ADD: begin
                        result = sum;
                        if (add_ovf) wr_en = 1'b0;
                    end
                    OP_ADDU: result = sum;
                    OP_SUB: begin
                        result = diff;
                        if (sub_ovf) wr_en = 1'b0;
                    end
                    OP_SUBU: result = diff;
                    OP_SLT:  result = {{(W-1){1'b0}}, $signed(op_a) < $signed(op_b)};
                    OP_SLTU: result = {{(W-1){1'b0}}, op_a < op_b};
                    default: result = '0;
                endcase
            end
            SEL_MOVE: begin
                case (aluop_in)
                    OP_MFHI: result = hi_q;
                    OP_MFLO: result = lo_q;
                    default: result = '0;
                endcase
            end
            SEL_DIV: wr_en = 1'b0;
            default: result = '0;
        endcase
    end

    // Combinational outputs are forced to zero while reset is held.
    assign reg_wr_addr_out = rst_n ? reg_wr_addr_in : '0;
    assign reg_wr_en_out   = rst_n && wr_en;
    assign reg_wr_data_out = rst_n ? result : '0;
    assign stall_req_out   = rst_n && (((state == S_IDLE) && div_req) || (state == S_BUSY));
    assign hi_out          = hi_q;
    assign lo_out          = lo_q;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed plan items plus randomized ops
// compared against an arithmetic reference model.
module tb_ex_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  reg_wr_addr_in = '0;
    logic        reg_wr_en_in = 1'b0;
    logic [31:0] reg_rd_data1_in = '0;
    logic [31:0] reg_rd_data2_in = '0;
    logic [2:0]  alusel_in = '0;
    logic [7:0]  aluop_in = '0;
    logic        flush_in = 1'b0;
    logic [4:0]  reg_wr_addr_out;
    logic        reg_wr_en_out;
    logic [31:0] reg_wr_data_out;
    logic        stall_req_out;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int checks = 0;
    int errors = 0;
    logic [31:0] hi_m = '0;
    logic [31:0] lo_m = '0;

    ex_stage dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .reg_wr_addr_in  (reg_wr_addr_in),
        .reg_wr_en_in    (reg_wr_en_in),
        .reg_rd_data1_in (reg_rd_data1_in),
        .reg_rd_data2_in (reg_rd_data2_in),
        .alusel_in       (alusel_in),
        .aluop_in        (aluop_in),
        .flush_in        (flush_in),
        .reg_wr_addr_out (reg_wr_addr_out),
        .reg_wr_en_out   (reg_wr_en_out),
        .reg_wr_data_out (reg_wr_data_out),
        .stall_req_out   (stall_req_out),
        .hi_out          (hi_out),
        .lo_out          (lo_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: architectural meaning of each op using wide integer arithmetic.
    function automatic void model(input logic [2:0] s, input logic [7:0] o,
                                  input logic [31:0] a, input logic [31:0] b, input logic wei,
                                  output logic [31:0] d, output logic e);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint r;
        int     sh = int'(b[4:0]);
        d = '0;
        e = wei;
        case (s)
            3'd1: case (o)
                8'h24: d = a & b;
                8'h25: d = a | b;
                8'h26: d = a ^ b;
                8'h27: d = ~(a | b);
                default: d = '0;
            endcase
            3'd2: case (o)
                8'h7C: d = a << sh;
                8'h02: d = a >> sh;
                8'h03: begin r = sa >>> sh; d = r[31:0]; end
                default: d = '0;
            endcase
            3'd3: case (o)
                8'h20: begin r = sa + sb; d = r[31:0]; e = wei && (r == longint'($signed(d))); end
                8'h21: d = a + b;
                8'h22: begin r = sa - sb; d = r[31:0]; e = wei && (r == longint'($signed(d))); end
                8'h23: d = a - b;
                8'h2A: d = {31'b0, sa < sb};
                8'h2B: d = {31'b0, a < b};
                default: d = '0;
            endcase
            3'd4: case (o)
                8'h10: d = hi_m;
                8'h12: d = lo_m;
                default: d = '0;
            endcase
            3'd5: e = 1'b0;
            default: d = '0;
        endcase
    endfunction

    function automatic void div_model(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] q, output logic [31:0] r);
        longint la, lb, lq, lr;
        if (b == 32'h0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sgn) begin
            la = longint'($signed(a));
            lb = longint'($signed(b));
            lq = la / lb;
            lr = la % lb;
            q  = lq[31:0];
            r  = lr[31:0];
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0: return 32'h7FFF_FFFF;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h0;
            4: return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    task automatic rand_op(output logic [2:0] s, output logic [7:0] o);
        case ($urandom_range(0, 18))
            0:  begin s = 3'd1; o = 8'h24; end
            1:  begin s = 3'd1; o = 8'h25; end
            2:  begin s = 3'd1; o = 8'h26; end
            3:  begin s = 3'd1; o = 8'h27; end
            4:  begin s = 3'd2; o = 8'h7C; end
            5:  begin s = 3'd2; o = 8'h02; end
            6:  begin s = 3'd2; o = 8'h03; end
            7:  begin s = 3'd3; o = 8'h20; end
            8:  begin s = 3'd3; o = 8'h21; end
            9:  begin s = 3'd3; o = 8'h22; end
            10: begin s = 3'd3; o = 8'h23; end
            11: begin s = 3'd3; o = 8'h2A; end
            12: begin s = 3'd3; o = 8'h2B; end
            13: begin s = 3'd4; o = 8'h10; end
            14: begin s = 3'd4; o = 8'h12; end
            15: begin s = 3'd1; o = 8'h99; end
            16: begin s = 3'd0; o = 8'($urandom); end
            17: begin s = 3'd3; o = 8'h7C; end
            default: begin s = 3'd7; o = 8'h20; end
        endcase
    endtask

    task automatic run_op(input logic [2:0] s, input logic [7:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic wei, input string tag);
        logic [31:0] ed;
        logic        ee;
        logic [4:0]  addr;
        addr = 5'($urandom);
        @(posedge clk); #1;
        alusel_in = s; aluop_in = o; reg_rd_data1_in = a; reg_rd_data2_in = b;
        reg_wr_addr_in = addr; reg_wr_en_in = wei; flush_in = 1'b0;
        model(s, o, a, b, wei, ed, ee);
        @(negedge clk);
        check({tag, "_data"}, reg_wr_data_out, ed);
        check({tag, "_en"}, {31'b0, reg_wr_en_out}, {31'b0, ee});
        check({tag, "_addr"}, {27'b0, reg_wr_addr_out}, {27'b0, addr});
        check({tag, "_stall"}, {31'b0, stall_req_out}, 32'h0);
    endtask

    // Issues a divide, counts stall cycles, then issues MFLO on the commit edge.
    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [31:0] eq, er;
        int          stalls;
        bit          done;
        div_model(sgn, a, b, eq, er);
        @(posedge clk); #1;
        alusel_in = 3'd5; aluop_in = sgn ? 8'h1A : 8'h1B; reg_rd_data1_in = a; reg_rd_data2_in = b;
        reg_wr_en_in = 1'b1; reg_wr_addr_in = 5'd9; flush_in = 1'b0;
        stalls = 0;
        done   = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (stall_req_out) begin
                if (stalls == 0) begin
                    check({tag, "_issue_en"}, {31'b0, reg_wr_en_out}, 32'h0);
                    check({tag, "_issue_data"}, reg_wr_data_out, 32'h0);
                end
                stalls++;
                @(posedge clk); #1;
            end else begin
                done = 1'b1;
            end
        end
        check({tag, "_stalls"}, 32'(stalls), (b == 32'h0) ? 32'd1 : 32'd33);
        if (done) begin
            check({tag, "_done_en"}, {31'b0, reg_wr_en_out}, 32'h0);
            check({tag, "_hi_precommit"}, hi_out, hi_m);
        end
        @(posedge clk); #1;
        hi_m = er;
        lo_m = eq;
        alusel_in = 3'd4; aluop_in = 8'h12; reg_wr_en_in = 1'b1;
        @(negedge clk);
        check({tag, "_lo"}, lo_out, eq);
        check({tag, "_hi"}, hi_out, er);
        check({tag, "_mflo"}, reg_wr_data_out, eq);
        check({tag, "_after_stall"}, {31'b0, stall_req_out}, 32'h0);
    endtask

    initial begin
        logic [2:0]  s;
        logic [7:0]  o;
        logic [31:0] a, b;

        // Reset: drive a live ADDU so gating of combinational outputs is visible.
        alusel_in = 3'd3; aluop_in = 8'h21; reg_rd_data1_in = 32'd5; reg_rd_data2_in = 32'd6;
        reg_wr_addr_in = 5'd3; reg_wr_en_in = 1'b1;
        #3;
        check("rst_data", reg_wr_data_out, 32'h0);
        check("rst_en", {31'b0, reg_wr_en_out}, 32'h0);
        check("rst_addr", {27'b0, reg_wr_addr_out}, 32'h0);
        check("rst_stall", {31'b0, stall_req_out}, 32'h0);
        check("rst_hi", hi_out, 32'h0);
        check("rst_lo", lo_out, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_op(3'd3, 8'h20, 32'h7FFF_FFFF, 32'h1, 1'b1, "add_ovf");
        check("add_ovf_const", reg_wr_data_out, 32'h8000_0000);
        check("add_ovf_en_const", {31'b0, reg_wr_en_out}, 32'h0);
        run_op(3'd3, 8'h21, 32'h7FFF_FFFF, 32'h1, 1'b1, "addu");
        check("addu_en_const", {31'b0, reg_wr_en_out}, 32'h1);
        run_op(3'd2, 8'h03, 32'h8000_0000, 32'd4, 1'b1, "sra");
        check("sra_const", reg_wr_data_out, 32'hF800_0000);
        run_op(3'd3, 8'h2A, 32'hFFFF_FFFF, 32'h1, 1'b1, "slt");
        check("slt_const", reg_wr_data_out, 32'h1);
        run_op(3'd3, 8'h2B, 32'hFFFF_FFFF, 32'h1, 1'b1, "sltu");
        check("sltu_const", reg_wr_data_out, 32'h0);
        run_op(3'd3, 8'h22, 32'h8000_0000, 32'h1, 1'b1, "sub_ovf");
        run_op(3'd4, 8'h10, 32'h0, 32'h0, 1'b1, "mfhi_reset");

        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
        check("div_m7_2_lo_const", lo_out, 32'hFFFF_FFFD);
        check("div_m7_2_hi_const", hi_out, 32'hFFFF_FFFF);
        run_div(1'b0, 32'd100, 32'd0, "divu_by0");
        check("divu_by0_lo_const", lo_out, 32'hFFFF_FFFF);
        check("divu_by0_hi_const", hi_out, 32'd100);
        run_div(1'b1, 32'hFFFF_FFF0, 32'd0, "div_neg_by0");
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_minint");

        // Flush in BUSY cycle 10: stall must drop next cycle, HI/LO keep their values.
        @(posedge clk); #1;
        alusel_in = 3'd5; aluop_in = 8'h1B; reg_rd_data1_in = 32'hFFFF_FFFF; reg_rd_data2_in = 32'd3;
        @(negedge clk);
        check("flush_issue_stall", {31'b0, stall_req_out}, 32'h1);
        repeat (10) @(posedge clk);
        #1;
        flush_in = 1'b1;
        @(negedge clk);
        check("flush_busy_stall", {31'b0, stall_req_out}, 32'h1);
        @(posedge clk); #1;
        flush_in = 1'b0; alusel_in = 3'd0; aluop_in = 8'h00;
        @(negedge clk);
        check("flush_stall_drop", {31'b0, stall_req_out}, 32'h0);
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("flush_hi_kept", hi_out, hi_m);
        check("flush_lo_kept", lo_out, lo_m);

        // Asynchronous reset in BUSY cycle 5.
        @(posedge clk); #1;
        alusel_in = 3'd5; aluop_in = 8'h1B; reg_rd_data1_in = 32'd1000; reg_rd_data2_in = 32'd7;
        reg_wr_addr_in = 5'd17; reg_wr_en_in = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        alusel_in = 3'd3; aluop_in = 8'h21; reg_rd_data1_in = 32'd5; reg_rd_data2_in = 32'd6;
        #1;
        check("mid_rst_stall", {31'b0, stall_req_out}, 32'h0);
        check("mid_rst_hi", hi_out, 32'h0);
        check("mid_rst_lo", lo_out, 32'h0);
        check("mid_rst_data", reg_wr_data_out, 32'h0);
        check("mid_rst_en", {31'b0, reg_wr_en_out}, 32'h0);
        check("mid_rst_addr", {27'b0, reg_wr_addr_out}, 32'h0);
        hi_m = '0;
        lo_m = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        alusel_in = 3'd0;
        run_div(1'b0, 32'd10, 32'd3, "divu_10_3");
        check("divu_10_3_lo_const", lo_out, 32'd3);
        check("divu_10_3_hi_const", hi_out, 32'd1);

        for (int i = 0; i < 80; i++) begin
            rand_op(s, o);
            run_op(s, o, rand_operand(), rand_operand(), 1'($urandom), "rand_op");
        end

        for (int i = 0; i < 10; i++) begin
            a = rand_operand();
            case ($urandom_range(0, 4))
                0: b = 32'h0;
                1: b = 32'($urandom_range(1, 9));
                2: b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            run_div(1'($urandom), a, b, "rand_div");
            run_op(3'd4, 8'h10, 32'h0, 32'h0, 1'b1, "rand_mfhi");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
